// File: rtl/hamming74_uart_tx_if.sv
// Nibble handshake between a producer and the Hamming(7,4) UART transmitter.
// The producer drives data/valid; the transmitter answers with ready.
interface hamming74_uart_tx_if;
  logic [3:0] data_in;
  logic       valid_in;
  logic       ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/hamming74_uart_tx.sv
// Hamming(7,4) encoder + UART frame serialiser (start, 7 code bits LSB first, stop).
// Optional HAMMING_TX_ERR_INJECT_EN adds inject_pos to flip one code bit on acceptance.
module hamming74_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  hamming74_uart_tx_if.slave   up,
`ifdef HAMMING_TX_ERR_INJECT_EN
  input  logic [2:0]           inject_pos,
`endif
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_out,
  output logic [6:0]           code_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [6:0]       code_q, code_d;
  logic             tx_q, tx_d;

  logic [3:0] d;
  logic [6:0] code_clean;
  logic [6:0] err_mask;
  logic [6:0] code_enc;
  logic       ready;
  logic       accept;
  logic       bit_end;
  logic [7:0] code_ext;

  // Codeword bit i-1 holds Hamming position i: {d4,d3,d2,p3,d1,p2,p1}
  assign d          = up.data_in;
  assign code_clean = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
                       d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};

`ifdef HAMMING_TX_ERR_INJECT_EN
  // inject_pos selects a 1-based code position; zero matches no bit.
  for (genvar gi = 0; gi < 7; gi++) begin : g_err_mask
    assign err_mask[gi] = (inject_pos == 3'(gi + 1));
  end
`else
  assign err_mask = '0;
`endif

  assign code_enc = code_clean ^ err_mask;

  assign ready   = (state_q == IDLE) && ena && rst_n;
  assign accept  = ready && up.valid_in;
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      code_q    <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      code_q    <= code_d;
      tx_q      <= tx_d;
    end
  end

  // With ena low every next-state value defaults to the current one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    code_d    = code_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          cnt_d     = '0;
          bit_idx_d = '0;
          if (accept) begin
            state_d = START;
            code_d  = code_enc;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_d = '0;
            if (bit_idx_q == BIT_LAST) begin
              bit_idx_d = '0;
              state_d   = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      endcase
    end
  end

  // tx is registered from the next state so the line never glitches.
  assign code_ext = {1'b0, code_d};

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = code_ext[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign up.ready_out = ready;
  assign tx           = tx_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == STOP) && bit_end && ena;
  assign state_out    = state_q;
  assign code_out     = code_q;

endmodule

// File: tb/tb_hamming74_uart_tx.sv
// Scoreboard bench for hamming74_uart_tx: driver queues expected frames, a negedge
// monitor rebuilds each UART frame from tx and checks it against the queue head.
module tb_hamming74_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       tx, busy, done;
  logic [2:0] state_out;
  logic [6:0] code_out;
`ifdef HAMMING_TX_ERR_INJECT_EN
  logic [2:0] inject_pos = 3'd0;
`endif

  hamming74_uart_tx_if bus ();

  hamming74_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .up        (bus),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .inject_pos(inject_pos),
`endif
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .state_out (state_out),
    .code_out  (code_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] code;
    logic [3:0] data;
    logic [2:0] syn;
    int         len;
    int         gap;
    bit         aborted;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Hand-computed Hamming(7,4) codewords for nibbles 0..F
  logic [6:0] ref_code [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [6:0] code, input logic [3:0] data, input logic [2:0] syn,
                          input int len, input int gap, input bit ab);
    exp_t e;
    e.code = code; e.data = data; e.syn = syn; e.len = len; e.gap = gap; e.aborted = ab;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.ready_out) return;
    end
    check("ready_timeout", 0, 1);
  endtask

  // Present a nibble until it is accepted; returns 1 ns into the first START cycle.
  task automatic offer(input logic [3:0] nib);
    bus.data_in  = nib;
    bus.valid_in = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        @(posedge clk); #1;
        return;
      end
    end
    check("idle_timeout", 0, 1);
  endtask

  // ---------------- monitor ----------------
  bit         m_active = 0, m_have = 0, m_gap_ok = 0, m_prev_ena = 1;
  int         m_idx, m_total, m_bad, m_done_cnt, m_done_bad, m_rdy_bad, m_gap = 0, m_gap_start;
  int         m_idle_bad = 0;
  logic [6:0] m_code, m_code_seen, m_rx;
  logic       m_prev_tx;
  logic [2:0] m_prev_state;

  initial begin
    exp_t       e;
    logic       exp_tx;
    logic [2:0] exp_st, syn;
    logic [6:0] corr;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (m_active && m_have) begin
          e = exp_q.pop_front();
          check("abort_expected", int'(e.aborted), 1);
          $display("[TB] frame code=%02h aborted by reset", e.code);
        end
        m_active = 0;
        m_gap_ok = 0;
        m_gap    = 0;
      end else if (busy) begin
        if (!m_active) begin
          m_active = 1; m_idx = 0; m_total = 0; m_bad = 0; m_done_cnt = 0;
          m_done_bad = 0; m_rdy_bad = 0; m_rx = '0; m_prev_ena = 1;
          m_gap_start = m_gap_ok ? m_gap : -1;
          m_code_seen = code_out;
          m_have = (exp_q.size() != 0);
          if (m_have) m_code = exp_q[0].code;
          else begin
            m_code = '0;
            check("unexpected_frame", 1, 0);
          end
        end else if (!m_prev_ena) begin
          if (tx !== m_prev_tx || state_out !== m_prev_state) m_bad++;
        end
        if (m_idx < CPB) begin
          exp_tx = 1'b0; exp_st = 3'd1;
        end else if (m_idx < 8 * CPB) begin
          exp_tx = m_code[(m_idx / CPB) - 1]; exp_st = 3'd2;
        end else begin
          exp_tx = 1'b1; exp_st = 3'd3;
        end
        if (m_idx >= 9 * CPB || tx !== exp_tx || state_out !== exp_st || code_out !== m_code_seen)
          m_bad++;
        if (ena && m_idx >= CPB && m_idx < 8 * CPB && (m_idx % CPB) == CPB / 2)
          m_rx[(m_idx / CPB) - 1] = tx;
        if (done) begin
          m_done_cnt++;
          if (!(m_idx == 9 * CPB - 1 && ena)) m_done_bad++;
        end
        if (bus.ready_out) m_rdy_bad++;
        m_total++;
        m_prev_tx = tx;
        m_prev_state = state_out;
        m_prev_ena = ena;
        if (ena) m_idx++;
      end else begin
        if (m_active) begin
          m_active = 0;
          if (m_have) begin
            e = exp_q.pop_front();
            syn  = {m_rx[3] ^ m_rx[4] ^ m_rx[5] ^ m_rx[6],
                    m_rx[1] ^ m_rx[2] ^ m_rx[5] ^ m_rx[6],
                    m_rx[0] ^ m_rx[2] ^ m_rx[4] ^ m_rx[6]};
            corr = m_rx;
            if (syn != 3'd0) corr[syn - 3'd1] = ~corr[syn - 3'd1];
            check("aborted_flag", int'(e.aborted), 0);
            check("code_out", m_code_seen, e.code);
            check("bit_pattern_errors", m_bad, 0);
            check("active_cycles", m_idx, 9 * CPB);
            check("frame_len", m_total, e.len);
            check("done_pulses", m_done_cnt, 1);
            check("done_position", m_done_bad, 0);
            check("ready_during_busy", m_rdy_bad, 0);
            check("idle_tx_high", m_idle_bad, 0);
            check("syndrome", syn, e.syn);
            check("decoded_data", {corr[6], corr[5], corr[4], corr[2]}, e.data);
            if (e.gap >= 0) check("idle_gap", m_gap_start, e.gap);
            $display("[TB] frame code=%02h rx=%02h len=%0d syn=%0d gap=%0d",
                     m_code_seen, m_rx, m_total, syn, m_gap_start);
          end
          m_idle_bad = 0;
          m_gap = 0;
          m_gap_ok = 1;
        end
        if (tx !== 1'b1) m_idle_bad++;
        m_gap++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.data_in  = 4'h0;
    bus.valid_in = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_ready", bus.ready_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_state", state_out, 0);
    check("reset_code", code_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", bus.ready_out, 1);

    push_exp(7'h55, 4'hB, 3'd0, 9 * CPB, -1, 1'b0);
    offer(4'hB);
    wait_idle();

    for (int n = 0; n < 16; n++) begin
      push_exp(ref_code[n], 4'(n), 3'd0, 9 * CPB, -1, 1'b0);
      offer(4'(n));
      wait_idle();
      repeat (2) @(posedge clk);
      #1;
    end

    // valid held high across two frames; mid-frame nibble changes are ignored
    push_exp(7'h07, 4'h1, 3'd0, 9 * CPB, -1, 1'b0);
    push_exp(7'h19, 4'h2, 3'd0, 9 * CPB, 1, 1'b0);
    bus.data_in  = 4'h1;
    bus.valid_in = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    bus.data_in = 4'h9;
    repeat (10) @(posedge clk);
    #1;
    bus.data_in = 4'h2;
    wait_ready();
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    // ena low for 10 cycles in DATA bit 3
    push_exp(7'h55, 4'hB, 3'd0, 9 * CPB + 10, -1, 1'b0);
    offer(4'hB);
    repeat (17) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("freeze_state", state_out, 2);
    repeat (5) @(posedge clk);
    #1;
    ena = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    // asynchronous reset while a zero data bit is on the line
    push_exp(7'h33, 4'h6, 3'd0, 0, -1, 1'b1);
    offer(4'h6);
    repeat (13) @(posedge clk);
    #1;
    check("pre_reset_tx", tx, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_state", state_out, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_code", code_out, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(7'h33, 4'h6, 3'd0, 9 * CPB, -1, 1'b0);
    offer(4'h6);
    wait_idle();

`ifdef HAMMING_TX_ERR_INJECT_EN
    inject_pos = 3'd3;
    push_exp(7'h51, 4'hB, 3'd3, 9 * CPB, -1, 1'b0);
    offer(4'hB);
    wait_idle();
    inject_pos = 3'd7;
    push_exp(7'h3F, 4'hF, 3'd7, 9 * CPB, -1, 1'b0);
    offer(4'hF);
    wait_idle();
    inject_pos = 3'd0;
`endif

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hamming74_uart_tx.md
Name: hamming74_uart_tx

Overview:
- Transmit-side counterpart of the UART receiver / Hamming(7,4) decoder path.
- Accepts a 4-bit nibble over a valid/ready handshake and encodes it to a 7-bit Hamming(7,4) codeword.
- Serialises the codeword as one UART frame on a single output line: start, 7 code bits LSB first, stop.
- Sits in the top level driving a spare uio/uo pin; used for loopback into the receiver.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; legal range 2 to 65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; low freezes all sequential state
- data_in  input  4  nibble to send; d1=data_in[0] .. d4=data_in[3]
- valid_in  input  1  data_in is valid
- ready_out  output  1  block can accept a nibble this cycle
- tx  output  1  UART serial line, idle high
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse at the end of the stop bit
- state_out  output  3  current FSM state, for debug
- code_out  output  7  latched codeword, for debug

Behaviour:
- Reset (async, rst_n=0) forces: state=IDLE, tx=1, ready_out=0 during reset, busy=0, done=0, code_out=0, and all counters 0.
- Reset mid-frame aborts the frame immediately; tx returns to 1.
- Codeword: bit[i-1] holds Hamming position i, i.e. {d4,d3,d2,p3,d1,p2,p1} for bits [6:0].
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p3 = d2^d3^d4
- ready_out = (state==IDLE) && ena. This is combinational from registered state.
- Handshake: a transfer occurs on a rising edge with valid_in && ready_out.
  - The codeword is latched into code_out on that edge.
  - FSM goes to START. tx=0 from the following cycle.
  - valid_in without ready_out is ignored; no queueing.
- FSM encoding: IDLE=3'd0, START=3'd1, DATA=3'd2, STOP=3'd3. Other codes are unreachable and recover to IDLE.
  - IDLE: tx=1. Go to START on transfer.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=code_out[bit_idx] for CLKS_PER_BIT cycles per bit. bit_idx increments 0..6; after bit 6 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, done=1 for exactly one cycle and the FSM goes to IDLE.
- Frame length: 9*CLKS_PER_BIT cycles from the first tx=0 cycle to the first cycle back in IDLE.
- Back-to-back: the earliest next acceptance is the first IDLE cycle, so a minimum of 1 idle-high cycle separates frames.
- busy = (state != IDLE).
- The baud counter is CLKS_PER_BIT wide enough: $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1 and wrapping to 0 at each bit boundary.
- ena=0: state, baud counter, bit index and tx are held. done is held low. Timing resumes exactly where it stopped when ena returns.
- code_out holds its value after the frame until the next acceptance.

Optional Feature:
- Macro: HAMMING_TX_ERR_INJECT_EN
- Defined:
  - Adds input port inject_pos [2:0].
  - On acceptance, if inject_pos is nonzero, codeword bit (inject_pos-1) is inverted before latching into code_out and transmission.
  - A single-bit error is therefore created; the downstream decoder syndrome must equal inject_pos.
  - inject_pos=0 means no error.
- Undefined: the port is absent and the codeword is always clean.

Test Plan:
- CLKS_PER_BIT=4, rst_n released, data_in=4'hB with valid_in pulsed -> code_out=7'h55; tx = 0,1,0,1,0,1,0,1,1, each held 4 cycles; done pulses once 36 cycles after the first start cycle; ready_out is low throughout the frame.
- data_in=4'h0 -> code 7'h00; data_in=4'hF -> 7'h7F; data_in=4'h1 -> 7'h07. All 16 nibbles must match the reference encoder and decode back via the receiver loopback with syndrome 0.
- Hold valid_in high continuously with 4'h1 then 4'h2 -> two frames separated by exactly 1 cycle of tx=1 in IDLE; the nibble value during busy is ignored.
- Deassert ena for 10 cycles during DATA bit 3 -> tx and state_out frozen; total frame length becomes 36+10 cycles; the bit pattern is unchanged.
- Assert rst_n=0 asynchronously mid-DATA -> tx=1, state_out=0, busy=0 within the same cycle (no clock needed). The next frame after release is clean.
- With HAMMING_TX_ERR_INJECT_EN: data_in=4'hB, inject_pos=3 -> code_out=7'h51. In loopback, the receiver decoder reports syndrome 3 and corrected data 4'hB.
